hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the stall and flush performance counters.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rstn, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have ports ID_rs1 and ID_rs2, input, 5 each: source registers of the instruction in ID.
REQ-005 SHALL have ports ID_use_rs1 and ID_use_rs2, input, 1 each: the ID instruction actually reads rs1 / rs2.
REQ-006 SHALL have port EX_MemRead, input, 1: the instruction in EX is a load.
REQ-007 SHALL have port EX_rd, input, 5: destination register of the instruction in EX.
REQ-008 SHALL have port EX_redirect, input, 1: a taken branch or jump resolved in EX this cycle.
REQ-009 SHALL have port EX_md_start, input, 1: a multi-cycle mul/div instruction is in EX.
REQ-010 SHALL have port md_done, input, 1: the mul/div result is valid this cycle.
REQ-011 SHALL have ports PC_Write, IF_ID_Write and ID_EX_Write, output, 1 each: enables; 1 means the stage advances.
REQ-012 SHALL have ports IF_ID_Flush, ID_EX_Flush and EX_MEM_Flush, output, 1 each: 1 loads a bubble (RegWrite=0, MemWrite=0).
REQ-013 SHALL have port md_busy, output, 1: the FSM is in MD_WAIT.
REQ-014 SHALL have ports stall_cnt and flush_cnt, output, CNT_W each: saturating performance counters.

Function
REQ-015 SHALL implement a 2-state FSM {RUN, MD_WAIT}; the enable and flush outputs are combinational from state and inputs.
REQ-016 SHALL default, with no condition active, to all Write outputs = 1 and all Flush outputs = 0.
REQ-017 SHALL raise load_use when EX_MemRead=1, EX_rd!=0, and (ID_use_rs1 with ID_rs1==EX_rd, or ID_use_rs2 with ID_rs2==EX_rd).
REQ-018 SHALL, in RUN with load_use and no higher-priority condition, output PC_Write=0, IF_ID_Write=0 and ID_EX_Flush=1 for exactly that cycle (1-cycle bubble).
REQ-019 SHALL, in RUN with EX_redirect=1, output IF_ID_Flush=1, ID_EX_Flush=1 and PC_Write=1, ignoring load_use and EX_md_start that cycle.
REQ-020 SHALL, in RUN with EX_md_start=1 and md_done=0, output PC_Write=0, IF_ID_Write=0, ID_EX_Write=0 and EX_MEM_Flush=1, and go to MD_WAIT.
REQ-021 SHALL, in RUN with EX_md_start=1 and md_done=1, produce no stall and stay in RUN.
REQ-022 SHALL, in MD_WAIT, hold PC_Write=0, IF_ID_Write=0, ID_EX_Write=0 and EX_MEM_Flush=1 while md_done=0, and ignore EX_redirect and load_use.
REQ-023 SHALL, in MD_WAIT with md_done=1, output default enables that cycle and go to RUN.
REQ-024 SHALL set md_busy=1 exactly when state==MD_WAIT.
REQ-025 SHALL apply priority in RUN as: redirect, then mul/div stall, then load_use.
REQ-026 SHALL increment stall_cnt by 1 on every edge where PC_Write==0, saturating at all-ones with no wrap.
REQ-027 SHALL increment flush_cnt by 1 on every edge where IF_ID_Flush==1, saturating at all-ones.
REQ-028 SHALL treat register x0 as never hazardous (EX_rd==0 never raises load_use).

Reset
REQ-029 SHALL, while rstn=0, asynchronously force state=RUN, stall_cnt=0, flush_cnt=0 and md_busy=0, with outputs at the REQ-016 default values.
REQ-030 SHALL abandon MD_WAIT immediately on a reset mid-operation, and the first edge after rstn rises SHALL evaluate from RUN.

Verification
REQ-031 SHALL cover load-use: EX_MemRead=1, EX_rd=5, ID_rs2=5, ID_use_rs2=1 -> one cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, then stall_cnt=1.
REQ-032 SHALL cover x0 and unused operands: EX_rd=0 or ID_use_rs1=0 with a matching register -> no stall, stall_cnt unchanged.
REQ-033 SHALL cover redirect together with load_use: EX_redirect=1 -> IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1, flush_cnt=1.
REQ-034 SHALL cover mul/div: EX_md_start=1, md_done asserted 4 cycles later -> md_busy=1 for 4 cycles, stall_cnt=4, then RUN with default outputs.
REQ-035 SHALL cover reset mid-operation: rstn=0 during MD_WAIT -> md_busy=0 and counters=0 immediately, without waiting for a clock edge.
REQ-036 SHALL cover saturation: CNT_W=4 with 20 stall cycles -> stall_cnt holds 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl -- pipeline hazard controller for a 5-stage in-order core.
//
// Resolves three hazard classes each cycle and drives the stage enables and
// bubble-insert (flush) controls:
//   * EX redirect (taken branch/jump) : flush IF/ID and ID/EX, PC keeps moving
//   * multi-cycle mul/div in EX       : freeze PC, IF/ID, ID/EX; bubble EX/MEM
//   * load-use on an ID source operand: 1-cycle bubble into ID/EX
// Priority in RUN is redirect > mul/div > load-use. While waiting on mul/div
// (MD_WAIT) the front end is frozen regardless of redirect/load-use.
//
// Ports
//   clk, rstn                     clock, async active-low reset
//   ID_rs1/ID_rs2, ID_use_rs1/2   ID instruction sources and their use bits
//   EX_MemRead, EX_rd             EX instruction is a load, its destination
//   EX_redirect                   taken branch/jump resolved in EX
//   EX_md_start, md_done          mul/div in EX, mul/div result valid
//   PC_Write, IF_ID_Write, ID_EX_Write     stage advance enables
//   IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush bubble-insert controls
//   md_busy                       FSM is waiting on mul/div
//   stall_cnt, flush_cnt          saturating performance counters
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_rd,
  input  logic             EX_redirect,
  input  logic             EX_md_start,
  input  logic             md_done,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             ID_EX_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic S_RUN     = 1'b0;
  localparam logic S_MD_WAIT = 1'b1;

  logic             state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             load_use;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = EX_MemRead && (EX_rd != 5'd0) &&
                    ((ID_use_rs1 && (ID_rs1 == EX_rd)) ||
                     (ID_use_rs2 && (ID_rs2 == EX_rd)));

  always_comb begin
    state_d      = state_q;
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Flush = 1'b0;
    // Controls sit at their idle values throughout reset, even though the
    // hazard inputs may be toggling.
    if (rstn) begin
      case (state_q)
        S_RUN: begin
          if (EX_redirect) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
          end else if (EX_md_start && !md_done) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Flush = 1'b1;
            state_d      = S_MD_WAIT;
          end else if (load_use) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
          end
        end
        default: begin // S_MD_WAIT
          if (md_done) begin
            state_d = S_RUN;
          end else begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Flush = 1'b1;
          end
        end
      endcase
    end
  end

  // Counters saturate at all-ones so long runs never wrap to a small value.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!PC_Write && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (IF_ID_Flush && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign md_busy   = (state_q == S_MD_WAIT);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl -- directed bench for hazard_ctrl. A vector table covers the
// single-cycle RUN behaviour; hand-written sequences cover load-use counting,
// the mul/div wait, asynchronous reset mid-operation and counter saturation
// (second instance with CNT_W=4).
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic        clk, rstn;
  logic [4:0]  ID_rs1, ID_rs2, EX_rd;
  logic        ID_use_rs1, ID_use_rs2, EX_MemRead;
  logic        EX_redirect, EX_md_start, md_done;

  logic        PC_Write, IF_ID_Write, ID_EX_Write;
  logic        IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, md_busy;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_PC_Write, s_IF_ID_Write, s_ID_EX_Write;
  logic        s_IF_ID_Flush, s_ID_EX_Flush, s_EX_MEM_Flush, s_md_busy;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_ctrl dut (
    .clk(clk), .rstn(rstn),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
    .EX_MemRead(EX_MemRead), .EX_rd(EX_rd),
    .EX_redirect(EX_redirect), .EX_md_start(EX_md_start), .md_done(md_done),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .ID_EX_Write(ID_EX_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
    .EX_MEM_Flush(EX_MEM_Flush), .md_busy(md_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .rstn(rstn),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
    .EX_MemRead(EX_MemRead), .EX_rd(EX_rd),
    .EX_redirect(EX_redirect), .EX_md_start(EX_md_start), .md_done(md_done),
    .PC_Write(s_PC_Write), .IF_ID_Write(s_IF_ID_Write), .ID_EX_Write(s_ID_EX_Write),
    .IF_ID_Flush(s_IF_ID_Flush), .ID_EX_Flush(s_ID_EX_Flush),
    .EX_MEM_Flush(s_EX_MEM_Flush), .md_busy(s_md_busy),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush}
  localparam logic [5:0] O_DEF  = 6'b111_000;
  localparam logic [5:0] O_LU   = 6'b001_010;
  localparam logic [5:0] O_RDIR = 6'b111_110;
  localparam logic [5:0] O_MD   = 6'b000_001;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2;
    logic       u1, u2, mr;
    logic [4:0] rd;
    logic       redir, mds, mdd;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [5:0] outs();
    return {PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    ID_rs1 = 0; ID_rs2 = 0; ID_use_rs1 = 0; ID_use_rs2 = 0;
    EX_MemRead = 0; EX_rd = 0; EX_redirect = 0; EX_md_start = 0; md_done = 0;
  endtask

  task automatic drive(input vec_t v);
    ID_rs1 = v.rs1; ID_rs2 = v.rs2; ID_use_rs1 = v.u1; ID_use_rs2 = v.u2;
    EX_MemRead = v.mr; EX_rd = v.rd;
    EX_redirect = v.redir; EX_md_start = v.mds; md_done = v.mdd;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    #2 rstn = 1'b0;
    #1;
    chk("reset_busy",  {31'd0, md_busy}, 32'd0);
    chk("reset_stall", {16'd0, stall_cnt}, 32'd0);
    chk("reset_flush", {16'd0, flush_cnt}, 32'd0);
    chk("reset_outs",  {26'd0, outs()}, {26'd0, O_DEF});
    // release between edges
    @(negedge clk); rstn = 1'b1;
    step();
  endtask

  int exp_stall, exp_flush;

  initial begin
    //          name             rs1 rs2 u1 u2 mr rd  rdir mds mdd exp
    vecs[0] = '{"idle",          0,  0,  0, 0, 0, 0,  0,   0,  0,  O_DEF};
    vecs[1] = '{"lu_rs2",        0,  5,  0, 1, 1, 5,  0,   0,  0,  O_LU};
    vecs[2] = '{"x0_no_hazard",  0,  0,  1, 1, 1, 0,  0,   0,  0,  O_DEF};
    vecs[3] = '{"rs1_unused",    7,  0,  0, 0, 1, 7,  0,   0,  0,  O_DEF};
    vecs[4] = '{"lu_rs1",        9,  0,  1, 0, 1, 9,  0,   0,  0,  O_LU};
    vecs[5] = '{"no_memread",    9,  0,  1, 0, 0, 9,  0,   0,  0,  O_DEF};
    vecs[6] = '{"redir_over_lu", 5,  0,  1, 0, 1, 5,  1,   0,  0,  O_RDIR};
    vecs[7] = '{"redir_over_md", 0,  0,  0, 0, 0, 0,  1,   1,  0,  O_RDIR};
    vecs[8] = '{"md_done_same",  0,  0,  0, 0, 0, 0,  0,   1,  1,  O_DEF};
    vecs[9] = '{"reg_mismatch",  3,  4,  1, 1, 1, 6,  0,   0,  0,  O_DEF};

    idle();
    rstn = 1'b0;
    #3;
    chk("por_busy",  {31'd0, md_busy}, 32'd0);
    chk("por_stall", {16'd0, stall_cnt}, 32'd0);
    chk("por_outs",  {26'd0, outs()}, {26'd0, O_DEF});
    @(negedge clk); rstn = 1'b1;
    step();

    // single load-use bubble, then counter reads 1
    drive(vecs[1]); #1;
    chk("lu_seq_outs", {26'd0, outs()}, {26'd0, O_LU});
    step();
    idle(); #1;
    chk("lu_seq_after", {26'd0, outs()}, {26'd0, O_DEF});
    chk("lu_seq_stall", {16'd0, stall_cnt}, 32'd1);
    chk("lu_seq_flush", {16'd0, flush_cnt}, 32'd0);

    // table: every vector leaves the FSM in RUN
    exp_stall = 1; exp_flush = 0;
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i]); #1;
      chk({vecs[i].name, "_outs"}, {26'd0, outs()}, {26'd0, vecs[i].exp});
      step();
      if (!vecs[i].exp[5]) exp_stall++;
      if (vecs[i].exp[2])  exp_flush++;
      chk({vecs[i].name, "_busy"},  {31'd0, md_busy}, 32'd0);
      chk({vecs[i].name, "_stall"}, {16'd0, stall_cnt}, exp_stall);
      chk({vecs[i].name, "_flush"}, {16'd0, flush_cnt}, exp_flush);
    end

    // mul/div: done arrives 4 cycles after start
    do_reset();
    begin
      int busy_cycles = 0;
      idle(); EX_md_start = 1; #1;
      chk("md_start_outs", {26'd0, outs()}, {26'd0, O_MD});
      step();
      EX_md_start = 0;
      for (int c = 0; c < 3; c++) begin
        if (md_busy) busy_cycles++;
        // redirect and load-use are ignored while waiting
        EX_redirect = (c == 1); EX_MemRead = 1; EX_rd = 5; ID_rs1 = 5; ID_use_rs1 = 1; #1;
        chk("md_wait_outs", {26'd0, outs()}, {26'd0, O_MD});
        step();
      end
      idle(); md_done = 1; #1;
      if (md_busy) busy_cycles++;
      chk("md_done_outs", {26'd0, outs()}, {26'd0, O_DEF});
      step();
      idle(); #1;
      chk("md_busy_cycles", busy_cycles, 32'd4);
      chk("md_end_busy",  {31'd0, md_busy}, 32'd0);
      chk("md_end_stall", {16'd0, stall_cnt}, 32'd4);
      chk("md_end_flush", {16'd0, flush_cnt}, 32'd0);
      chk("md_end_outs",  {26'd0, outs()}, {26'd0, O_DEF});
    end

    // reset in the middle of MD_WAIT takes effect without a clock edge
    idle(); EX_md_start = 1; step();
    EX_md_start = 0;
    chk("mid_pre_busy", {31'd0, md_busy}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_busy",  {31'd0, md_busy}, 32'd0);
    chk("mid_rst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("mid_rst_outs",  {26'd0, outs()}, {26'd0, O_DEF});
    @(negedge clk); rstn = 1'b1;
    step();
    chk("mid_post_busy",  {31'd0, md_busy}, 32'd0);
    chk("mid_post_stall", {16'd0, stall_cnt}, 32'd0);

    // saturation: 20 load-use stalls into a 4-bit counter
    do_reset();
    drive(vecs[1]);
    repeat (20) step();
    idle(); #1;
    chk("sat4_stall",  {28'd0, s_stall_cnt}, 32'd15);
    chk("sat16_stall", {16'd0, stall_cnt}, 32'd20);
    chk("sat4_flush",  {28'd0, s_flush_cnt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

endmodule
